pll_reset_sequencer: RTL and testbench

Power-up and lock supervisor for the on-chip PLL that clocks the RVMyth core. Runs on the always-on clock. Enables the PLL VCO, waits for settling and a stable lock indication, then releases the core's active-high reset. On lock loss it holds the core in reset, power-cycles the VCO and retries a bounded number of times before latching a fault.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer.
// State encoding, retry width and a sizing helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_SETTLE = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_RETRY  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int RETRY_W = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Both stages clear to 0 under reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async input through two flops
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up and lock supervisor.
// Gates the core reset on a settled, stable PLL lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int OFF_CYCLES    = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_en_req,
  input  logic               pll_lock_raw,
  output logic               en_vco,
  output logic               core_reset,
  output logic               pll_ready,
  output logic               fault,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_MAX =
    max2(SETTLE_CYCLES, max2(STABLE_CYCLES, OFF_CYCLES));
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMO_W =
    (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] SETTLE_END =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_END =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_END =
    CNT_W'(OFF_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END =
    TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRY);

  state_t             cur, nxt;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TMO_W-1:0]   tmo, tmo_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock_raw),
    .q     (lock_s)
  );

  // state, counters and retry register
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_OFF;
      cnt     <= '0;
      tmo     <= '0;
      retry_q <= '0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_n;
      tmo     <= tmo_n;
      retry_q <= retry_n;
    end
  end

  // next state and counter updates; a dropped request wins
  always_comb begin
    nxt     = cur;
    cnt_n   = cnt;
    tmo_n   = tmo;
    retry_n = retry_q;
    case (cur)
      S_OFF: begin
        cnt_n   = '0;
        tmo_n   = '0;
        retry_n = '0;
        if (pll_en_req) nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_END) begin
          nxt   = S_STABLE;
          cnt_n = '0;
          tmo_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        tmo_n = tmo + 1'b1;
        if (lock_s && cnt == STABLE_END) begin
          nxt   = S_RUN;
          cnt_n = '0;
          tmo_n = '0;
        end else if (tmo == TMO_END) begin
          nxt   = S_RETRY;
          cnt_n = '0;
          tmo_n = '0;
        end else begin
          cnt_n = lock_s ? cnt + 1'b1 : '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          nxt   = S_RETRY;
          cnt_n = '0;
        end
      end
      S_RETRY: begin
        if (cnt == OFF_END) begin
          cnt_n = '0;
          if (retry_q == RETRY_MAX) begin
            nxt = S_FAULT;
          end else begin
            retry_n = retry_q + 1'b1;
            nxt     = S_SETTLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_FAULT: begin
        nxt = S_FAULT;
      end
      default: begin
        nxt = S_OFF;
      end
    endcase
    if (!pll_en_req && cur != S_OFF) begin
      nxt     = S_OFF;
      cnt_n   = '0;
      tmo_n   = '0;
      retry_n = '0;
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    en_vco     = 1'b0;
    core_reset = 1'b1;
    pll_ready  = 1'b0;
    fault      = 1'b0;
    case (cur)
      S_SETTLE, S_STABLE: begin
        en_vco = 1'b1;
      end
      S_RUN: begin
        en_vco     = 1'b1;
        core_reset = 1'b0;
        pll_ready  = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state     = cur;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer.
// Vector table, directed corners and a random run.
module tb_pll_reset_sequencer;

  localparam int P_SETTLE = 8;
  localparam int P_STABLE = 4;
  localparam int P_TMO    = 32;
  localparam int P_OFF    = 4;
  localparam int P_MAXR   = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_i = 1'b0;
  logic       raw_i = 1'b0;
  logic       en_vco, core_reset, pll_ready, fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .SETTLE_CYCLES (P_SETTLE),
    .STABLE_CYCLES (P_STABLE),
    .LOCK_TIMEOUT  (P_TMO),
    .OFF_CYCLES    (P_OFF),
    .MAX_RETRY     (P_MAXR)
  ) dut (
    .clk          (clk),
    .reset        (rst_i),
    .pll_en_req   (req_i),
    .pll_lock_raw (raw_i),
    .en_vco       (en_vco),
    .core_reset   (core_reset),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .state        (state),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  // reference model: phases with elapsed age and a lock streak
  int m_ph = 0;
  int m_age = 0;
  int m_streak = 0;
  int m_retry = 0;
  int lh[$] = '{0, 0};

  always @(posedge clk) begin
    int ls;
    int prev;
    ls   = lh[0];
    prev = m_ph;
    if (rst_i) begin
      m_ph = 0;
      m_age = 0;
      m_streak = 0;
      m_retry = 0;
      lh = '{0, 0};
    end else begin
      m_age++;
      case (m_ph)
        0: if (req_i) begin
          m_ph = 1;
          m_age = 0;
        end
        1: if (m_age == P_SETTLE) begin
          m_ph = 2;
          m_age = 0;
          m_streak = 0;
        end
        2: begin
          m_streak = (ls != 0) ? m_streak + 1 : 0;
          if (m_streak == P_STABLE) begin
            m_ph = 3;
            m_age = 0;
          end else if (m_age == P_TMO) begin
            m_ph = 4;
            m_age = 0;
          end
        end
        3: if (ls == 0) begin
          m_ph = 4;
          m_age = 0;
        end
        4: if (m_age == P_OFF) begin
          m_age = 0;
          if (m_retry == P_MAXR) m_ph = 5;
          else begin
            m_retry++;
            m_ph = 1;
          end
        end
        default: ;
      endcase
      if (!req_i && prev != 0) begin
        m_ph = 0;
        m_age = 0;
      end
      if (m_ph == 0) m_retry = 0;
      void'(lh.pop_front());
      lh.push_back(int'(raw_i));
    end
  end

  function automatic logic [3:0] dec(input int ph);
    logic e, c, r, f;
    e = (ph == 1 || ph == 2 || ph == 3);
    c = (ph != 3);
    r = (ph == 3);
    f = (ph == 5);
    return {e, c, r, f};
  endfunction

  task automatic check_model();
    logic [3:0] act;
    act = {en_vco, core_reset, pll_ready, fault};
    n_checks++;
    if (state !== 3'(m_ph) || retry_cnt !== 4'(m_retry) ||
        act !== dec(m_ph)) begin
      n_fail++;
      $display("FAIL model t=%0t st=%0d rc=%0d o=%b want st=%0d rc=%0d o=%b",
               $time, state, retry_cnt, act, m_ph, m_retry, dec(m_ph));
    end
  endtask

  task automatic check_exp(input string nm, input int st, input int rc);
    logic [3:0] act;
    act = {en_vco, core_reset, pll_ready, fault};
    n_checks++;
    if (state !== 3'(st) || retry_cnt !== 4'(rc) || act !== dec(st)) begin
      n_fail++;
      $display("FAIL %s st=%0d rc=%0d o=%b want st=%0d rc=%0d o=%b",
               nm, state, retry_cnt, act, st, rc, dec(st));
    end
  endtask

  task automatic step(input logic r, input logic q, input logic l);
    rst_i = r;
    req_i = q;
    raw_i = l;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic rst;
    logic req;
    logic raw;
    int   n;
    int   st;
    int   rc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic rq, rw;
    int   div;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 3, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1, 1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 7, 1, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 2, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3, 2, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1, 3, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2, 3, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 4, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3, 4, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1, 1, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1, 0, 0};

    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < tbl[v].n; k++)
        step(tbl[v].rst, tbl[v].req, tbl[v].raw);
      check_exp($sformatf("vec%0d", v), tbl[v].st, tbl[v].rc);
    end

    // one-cycle lock glitch while in STABLE
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(1'b0, 1'b1, (i == 10) ? 1'b0 : 1'b1);
      if (i == 12) check_exp("glitch_hold", 2, 0);
      if (i == 15) check_exp("glitch_late", 2, 0);
      if (i == 16) check_exp("glitch_run", 3, 0);
    end

    // lock never asserts: three timeouts end in FAULT
    do_reset();
    for (int i = 0; i < 140; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 40)  check_exp("tmo1", 4, 0);
      if (i == 44)  check_exp("retry1", 1, 1);
      if (i == 88)  check_exp("retry2", 1, 2);
      if (i == 128) check_exp("tmo3", 4, 2);
      if (i == 132) check_exp("fault_in", 5, 2);
      if (i == 139) check_exp("fault_hold", 5, 2);
    end
    step(1'b0, 1'b0, 1'b0);
    check_exp("fault_exit", 0, 0);

    // request dropped mid-SETTLE restarts the full settle
    do_reset();
    for (int i = 0; i <= 15; i++) begin
      step(1'b0, (i == 6) ? 1'b0 : 1'b1, 1'b1);
      if (i == 5)  check_exp("drop_pre", 1, 0);
      if (i == 6)  check_exp("drop_off", 0, 0);
      if (i == 14) check_exp("resettle", 1, 0);
      if (i == 15) check_exp("restable", 2, 0);
    end

    // synchronous reset taken while in RUN
    do_reset();
    for (int i = 0; i <= 12; i++) step(1'b0, 1'b1, 1'b1);
    check_exp("run_pre_rst", 3, 0);
    step(1'b1, 1'b1, 1'b1);
    check_exp("rst_in_run", 0, 0);
    step(1'b0, 1'b0, 1'b1);
    check_exp("post_rst_off", 0, 0);

    // random run against the model
    do_reset();
    rq  = 1'b1;
    rw  = 1'b0;
    div = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: div = 4;
          1: div = 40;
          default: div = 2000;
        endcase
      end
      if (rq) begin
        if ($urandom_range(0, 99) == 0) rq = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) rq = 1'b1;
      end
      if ($urandom_range(0, div - 1) == 0) rw = ~rw;
      step(($urandom_range(0, 599) == 0), rq, rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
